scan_index_sequencer: RTL and testbench
=======================================

Name: scan_index_sequencer

Overview:
- Sequential index generator that walks a 4-bit channel index through the enabled channels of a 16-channel mask.
- Holds each channel for a programmable dwell time.
- Sits directly upstream of the 4-to-16 one-hot decoder: idx drives the decoder select input, and idx_valid gates the decoder outputs downstream.
- Supports single-pass and continuous scan, with start/stop control and done/error pulses.

Parameters:
- N_CH, 16, number of channels; must equal 2**IDX_W.
- IDX_W, 4, index width; matches the decoder select width.
- DWELL_W, 8, width of the dwell field; each channel is held for dwell+1 cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- stop  in  1  abort request; effective only while scanning.
- ch_mask  in  N_CH  channel enable mask; bit n enables channel n; latched on accepted start.
- dwell  in  DWELL_W  hold count; latched on accepted start.
- one_shot  in  1  1 = single pass then DONE; 0 = continuous wrap; latched on accepted start.
- idx  out  IDX_W  current channel index to the decoder.
- idx_valid  out  1  idx is a live selection.
- busy  out  1  high in SCAN and DONE states.
- done  out  1  one-cycle pulse at the end of a one-shot pass.
- err_empty  out  1  one-cycle pulse when start is accepted with ch_mask == 0.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high; clk/rst as named above.
  - All outputs are 0 after a rising edge with rst=1: idx=0, idx_valid=0, busy=0, done=0, err_empty=0.
  - Latched mask, dwell and mode, plus the dwell counter, are cleared.
  - rst has priority over every other input. Reset mid-scan aborts immediately, with no done pulse.
- States: IDLE, SCAN, DONE. All outputs are registered.
- IDLE:
  - start=1 and ch_mask!=0: latch mask/dwell/one_shot; next cycle idx = lowest set bit of ch_mask, idx_valid=1, dwell counter = dwell; go to SCAN.
  - start=1 and ch_mask==0: err_empty=1 for one cycle; stay in IDLE.
  - stop is ignored in IDLE, so start+stop in the same cycle starts a scan.
- SCAN:
  - Counter nonzero: decrement it; idx unchanged.
  - Counter==0: reload the counter with the latched dwell; idx = next set bit strictly above idx.
  - If there is no higher set bit and one_shot=0, wrap to the lowest set bit.
  - If there is no higher set bit and one_shot=1, go to DONE: idx_valid=0, idx=0, done=1.
  - A single-bit mask in continuous mode holds the same idx indefinitely, with idx_valid=1.
- stop=1 in SCAN: next cycle idx_valid=0, idx=0, state IDLE; done is not asserted. stop takes priority over a same-cycle index advance.
- start in SCAN or DONE is ignored. Latched values are unaffected by input changes during a scan.
- DONE: lasts exactly one cycle with done=1 and busy=1, then returns to IDLE. A start on the DONE cycle is ignored.
- Latency:
  - start accepted at edge k: first idx valid in cycle k+1.
  - Each channel holds for dwell+1 cycles.
  - One-shot pass over M enabled channels: done asserted in cycle k+1+M*(dwell+1).
- Next-set-bit search: combinational over the latched mask. Indices wrap modulo N_CH; there is no arithmetic overflow beyond IDX_W.

Optional Feature:
- Macro: SCAN_ONEHOT_OUT_EN.
- Defined: adds output sel_onehot [N_CH-1:0], registered, equal to (1 << idx) when idx_valid=1, else 0. It updates on the same edge as idx, resets to 0, and lets downstream logic bypass the external decoder.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package scan_pkg holds:
  - state typedef scan_state_t {IDLE, SCAN, DONE};
  - constants SCAN_N_CH=16, SCAN_IDX_W=4, SCAN_DWELL_W=8;
  - function next_set_idx(mask, cur, wrap) returning {found, idx}.
- One sub-module: scan_dwell_counter, a loadable down-counter with load, en, and zero flag.

Test Plan:
- Basic one-shot: ch_mask=16'h0001, dwell=0, one_shot=1, start at edge k → idx=0 with idx_valid=1 in cycle k+1 only; done=1 in k+2; busy=0 in k+3.
- Multi-channel dwell: ch_mask=16'h8421, dwell=2, one_shot=1 → idx 0 in cycles k+1..k+3, idx 5 in k+4..k+6, idx 10 in k+7..k+9, idx 15 in k+10..k+12; done in k+13.
- Continuous wrap and stop: ch_mask=16'h8001, dwell=0, one_shot=0 → idx sequence 0,15,0,15,…; stop asserted on a cycle with idx=15 → idx_valid=0 and busy=0 next cycle; done never asserted.
- Empty mask and busy start: start with ch_mask=0 → err_empty one-cycle pulse, busy stays 0. Start during a scan with a different mask → sequence unchanged.
- Reset mid-scan: rst=1 during SCAN with dwell=5 → next cycle all outputs 0, state IDLE. A start after deassertion restarts from the lowest set bit.
- With SCAN_ONEHOT_OUT_EN defined: ch_mask=16'h0024, dwell=1, one_shot=1 → sel_onehot = 16'h0004 for 2 cycles, then 16'h0020 for 2 cycles, then 0 alongside done.

Source files
------------

// File: rtl/scan_index_sequencer_pkg.sv
// Shared types, constants and the next-set-bit search for the scan index sequencer.
// Package name: scan_pkg.
//   scan_state_t  : sequencer states IDLE / SCAN / DONE
//   SCAN_*        : default channel count, index width and dwell width
//   next_set_idx  : returns {found, idx} for the next enabled channel strictly above cur,
//                   optionally wrapping to the lowest enabled channel
package scan_pkg;

    localparam int unsigned SCAN_N_CH    = 16;
    localparam int unsigned SCAN_IDX_W   = 4;
    localparam int unsigned SCAN_DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Descending loops leave the lowest qualifying bit in idx.
    // Passing cur = all-ones with wrap = 1 yields the lowest set bit of the mask.
    function automatic logic [SCAN_IDX_W:0] next_set_idx(
        input logic [SCAN_N_CH-1:0]  mask,
        input logic [SCAN_IDX_W-1:0] cur,
        input logic                  wrap
    );
        logic                  found;
        logic [SCAN_IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = SCAN_N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                found = 1'b1;
                idx   = SCAN_IDX_W'(i);
            end
        end
        if (!found && wrap) begin
            for (int i = SCAN_N_CH - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    found = 1'b1;
                    idx   = SCAN_IDX_W'(i);
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/scan_index_sequencer_if.sv
// Control/status bundle of the scan index sequencer.
// master: drives start/stop/ch_mask/dwell/one_shot, observes the index outputs.
// slave : the sequencer itself.
// Optional output sel_onehot exists only when SCAN_ONEHOT_OUT_EN is defined.
interface scan_index_sequencer_if
    import scan_pkg::*;
#(
    parameter int unsigned N_CH    = SCAN_N_CH,
    parameter int unsigned IDX_W   = SCAN_IDX_W,
    parameter int unsigned DWELL_W = SCAN_DWELL_W
) ();
    logic               start;
    logic               stop;
    logic [N_CH-1:0]    ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic               one_shot;
    logic [IDX_W-1:0]   idx;
    logic               idx_valid;
    logic               busy;
    logic               done;
    logic               err_empty;
`ifdef SCAN_ONEHOT_OUT_EN
    logic [N_CH-1:0]    sel_onehot;
`endif

    modport master (
        output start, stop, ch_mask, dwell, one_shot,
`ifdef SCAN_ONEHOT_OUT_EN
        input  sel_onehot,
`endif
        input  idx, idx_valid, busy, done, err_empty
    );

    modport slave (
        input  start, stop, ch_mask, dwell, one_shot,
`ifdef SCAN_ONEHOT_OUT_EN
        output sel_onehot,
`endif
        output idx, idx_valid, busy, done, err_empty
    );
endinterface

// File: rtl/scan_index_sequencer_dwell_counter.sv
// scan_dwell_counter: loadable down-counter timing how long a channel is held.
//   clk, rst   : clock, synchronous active-high reset (clears the count)
//   i_load     : load i_load_val (takes priority over i_en)
//   i_en       : decrement by one
//   o_zero     : count is zero
module scan_dwell_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/scan_index_sequencer.sv
// scan_index_sequencer: walks a channel index through the enabled bits of a channel mask,
// holding each channel for dwell+1 cycles; single-pass or continuous.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of scan_index_sequencer_if
//              in : start, stop, ch_mask, dwell, one_shot
//              out: idx, idx_valid, busy, done, err_empty (all registered)
// Optional macro SCAN_ONEHOT_OUT_EN adds registered bus.sel_onehot = idx_valid ? 1 << idx : 0.
module scan_index_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned N_CH    = SCAN_N_CH,
    parameter int unsigned IDX_W   = SCAN_IDX_W,
    parameter int unsigned DWELL_W = SCAN_DWELL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    scan_index_sequencer_if.slave  bus
);
    scan_state_t        r_state, w_state_d;
    logic [N_CH-1:0]    r_mask, w_mask_d;
    logic [DWELL_W-1:0] r_dwell, w_dwell_d;
    logic               r_one_shot, w_one_shot_d;
    logic [IDX_W-1:0]   r_idx, w_idx_d;
    logic               r_valid, w_valid_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic               r_err, w_err_d;

    logic               w_cnt_load, w_cnt_en, w_cnt_zero;
    logic [DWELL_W-1:0] w_cnt_val;
    logic [IDX_W:0]     w_first, w_next;

    scan_dwell_counter #(
        .WIDTH (DWELL_W)
    ) u_dwell_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_en       (w_cnt_en),
        .i_load_val (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    // Start: lowest set bit of the incoming mask; found == mask nonzero.
    assign w_first = next_set_idx(bus.ch_mask, '1, 1'b1);
    // Advance: continuous mode wraps, one-shot reports not-found at the end of the pass.
    assign w_next  = next_set_idx(r_mask, r_idx, ~r_one_shot);

    always_comb begin
        w_state_d    = r_state;
        w_mask_d     = r_mask;
        w_dwell_d    = r_dwell;
        w_one_shot_d = r_one_shot;
        w_idx_d      = r_idx;
        w_valid_d    = r_valid;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_err_d      = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        w_cnt_val    = r_dwell;

        unique case (r_state)
            IDLE: begin
                w_idx_d   = '0;
                w_valid_d = 1'b0;
                w_busy_d  = 1'b0;
                if (bus.start) begin
                    if (w_first[IDX_W]) begin
                        w_mask_d     = bus.ch_mask;
                        w_dwell_d    = bus.dwell;
                        w_one_shot_d = bus.one_shot;
                        w_idx_d      = w_first[IDX_W-1:0];
                        w_valid_d    = 1'b1;
                        w_busy_d     = 1'b1;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = bus.dwell;
                        w_state_d    = SCAN;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    w_idx_d   = '0;
                    w_valid_d = 1'b0;
                    w_busy_d  = 1'b0;
                    w_state_d = IDLE;
                end else if (!w_cnt_zero) begin
                    w_cnt_en = 1'b1;
                end else if (w_next[IDX_W]) begin
                    w_idx_d    = w_next[IDX_W-1:0];
                    w_cnt_load = 1'b1;
                end else begin
                    w_idx_d   = '0;
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_idx_d   = '0;
                w_valid_d = 1'b0;
                w_busy_d  = 1'b0;
                w_state_d = IDLE;
            end
            default: begin
                w_idx_d   = '0;
                w_valid_d = 1'b0;
                w_busy_d  = 1'b0;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_dwell    <= '0;
            r_one_shot <= 1'b0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_mask     <= w_mask_d;
            r_dwell    <= w_dwell_d;
            r_one_shot <= w_one_shot_d;
            r_idx      <= w_idx_d;
            r_valid    <= w_valid_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_err      <= w_err_d;
        end
    end

    assign bus.idx       = r_idx;
    assign bus.idx_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err_empty = r_err;

`ifdef SCAN_ONEHOT_OUT_EN
    logic [N_CH-1:0] r_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
        end else begin
            r_sel <= w_valid_d ? (N_CH'(1) << w_idx_d) : '0;
        end
    end

    assign bus.sel_onehot = r_sel;
`endif
endmodule

// File: tb/tb_scan_index_sequencer.sv
// Self-checking bench for scan_index_sequencer: directed scenarios plus randomized masks,
// compared cycle by cycle against a schedule model (enabled-channel list, dwell, mode).
// Honours SCAN_ONEHOT_OUT_EN for the optional one-hot output.
module tb_scan_index_sequencer;
    import scan_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    scan_index_sequencer_if bus_if ();

    scan_index_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int idx;
        bit valid;
        bit busy;
        bit done;
    } exp_t;

    int m_ch[$];
    int m_dwell;
    bit m_os;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs t cycles after the accepting edge (t >= 1).
    function automatic exp_t model(input int t);
        exp_t e;
        int   pos;
        int   m;
        m   = m_ch.size();
        pos = (t - 1) / (m_dwell + 1);
        e   = '{idx: 0, valid: 1'b0, busy: 1'b0, done: 1'b0};
        if (!m_os) begin
            e = '{idx: m_ch[pos % m], valid: 1'b1, busy: 1'b1, done: 1'b0};
        end else if (pos < m) begin
            e = '{idx: m_ch[pos], valid: 1'b1, busy: 1'b1, done: 1'b0};
        end else if (pos == m && ((t - 1) % (m_dwell + 1)) == 0) begin
            e = '{idx: 0, valid: 1'b0, busy: 1'b1, done: 1'b1};
        end
        return e;
    endfunction

    task automatic chk_out(input string tag, input exp_t e, input bit err);
        chk({tag, ".idx"}, 32'(bus_if.idx), 32'(e.idx));
        chk({tag, ".valid"}, 32'(bus_if.idx_valid), 32'(e.valid));
        chk({tag, ".busy"}, 32'(bus_if.busy), 32'(e.busy));
        chk({tag, ".done"}, 32'(bus_if.done), 32'(e.done));
        chk({tag, ".err"}, 32'(bus_if.err_empty), 32'(err));
`ifdef SCAN_ONEHOT_OUT_EN
        chk({tag, ".onehot"}, 32'(bus_if.sel_onehot), e.valid ? (32'd1 << e.idx) : 32'd0);
`endif
    endtask

    // Start a scan and follow it for `cycles` cycles; optionally stop or reset at cycle
    // stop_t / rst_t, and drive conflicting inputs while busy when junk is set.
    task automatic run(input string tag, input logic [15:0] mask, input int dw, input bit os,
                       input int cycles, input int stop_t, input int rst_t, input bit junk,
                       input bit stop_at_start);
        exp_t idle_e;
        exp_t e;
        idle_e = '{idx: 0, valid: 1'b0, busy: 1'b0, done: 1'b0};
        m_ch.delete();
        for (int i = 0; i < 16; i++) if (mask[i]) m_ch.push_back(i);
        m_dwell = dw;
        m_os    = os;
        bus_if.ch_mask  = mask;
        bus_if.dwell    = 8'(dw);
        bus_if.one_shot = os;
        bus_if.stop     = stop_at_start;
        bus_if.start    = 1'b1;
        step();
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        for (int t = 1; t <= cycles; t++) begin
            e = model(t);
            chk_out($sformatf("%s.t%0d", tag, t), e, 1'b0);
            if (junk && e.busy) begin
                bus_if.start    = 1'($urandom);
                bus_if.ch_mask  = 16'($urandom);
                bus_if.dwell    = 8'($urandom);
                bus_if.one_shot = 1'($urandom);
            end else begin
                bus_if.start = 1'b0;
            end
            if (t == stop_t) begin
                bus_if.stop = 1'b1;
                step();
                bus_if.stop  = 1'b0;
                bus_if.start = 1'b0;
                chk_out({tag, ".stopped"}, idle_e, 1'b0);
                step();
                chk_out({tag, ".stopped2"}, idle_e, 1'b0);
                return;
            end
            if (t == rst_t) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                bus_if.start = 1'b0;
                chk_out({tag, ".reset"}, idle_e, 1'b0);
                return;
            end
            step();
        end
        bus_if.start = 1'b0;
    endtask

    initial begin
        exp_t        idle_e;
        logic [15:0] rmask;
        int          rdw;
        bit          ros;
        idle_e = '{idx: 0, valid: 1'b0, busy: 1'b0, done: 1'b0};
        bus_if.start    = 1'b1;
        bus_if.stop     = 1'b0;
        bus_if.ch_mask  = 16'h00F0;
        bus_if.dwell    = 8'd3;
        bus_if.one_shot = 1'b0;
        step();
        step();
        chk_out("reset", idle_e, 1'b0);
        bus_if.start = 1'b0;
        rst = 1'b0;
        step();
        chk_out("post_reset", idle_e, 1'b0);

        // Single channel, single pass.
        run("one_ch", 16'h0001, 0, 1'b1, 3, -1, -1, 1'b0, 1'b0);
        // Four channels with dwell 2, ignoring start/mask changes during the scan.
        run("multi", 16'h8421, 2, 1'b1, 14, -1, -1, 1'b1, 1'b0);
        // Continuous wrap 0,15,0,15; stop while idx = 15.
        run("wrap", 16'h8001, 0, 1'b0, 4, 4, -1, 1'b0, 1'b0);
        // Single-bit mask in continuous mode holds forever; start+stop together still starts.
        run("hold", 16'h0200, 1, 1'b0, 9, 9, -1, 1'b0, 1'b1);
        // Stop on the cycle the index would advance.
        run("stop_adv", 16'h0030, 1, 1'b0, 2, 2, -1, 1'b0, 1'b0);

        // Empty mask raises a one-cycle error pulse only.
        bus_if.ch_mask = 16'h0000;
        bus_if.start   = 1'b1;
        step();
        bus_if.start = 1'b0;
        chk_out("empty", idle_e, 1'b1);
        step();
        chk_out("empty2", idle_e, 1'b0);

        // Reset mid-scan, then restart from the lowest set bit.
        run("rst_mid", 16'h0C30, 5, 1'b0, 8, -1, 8, 1'b0, 1'b0);
        run("restart", 16'h0C30, 5, 1'b1, 26, -1, -1, 1'b0, 1'b0);

        // Two-channel dwell 1 pass.
        run("onehot", 16'h0024, 1, 1'b1, 6, -1, -1, 1'b0, 1'b0);

        // Randomized masks, dwells and modes.
        for (int r = 0; r < 12; r++) begin
            rmask = 16'($urandom) & 16'($urandom);
            if (rmask == 16'h0000) rmask = 16'h4000;
            rdw = int'($urandom_range(0, 3));
            ros = 1'($urandom);
            if (ros) begin
                run($sformatf("rnd%0d", r), rmask, rdw, 1'b1,
                    $countones(rmask) * (rdw + 1) + 2, -1, -1, 1'b1, 1'b0);
            end else begin
                run($sformatf("rnd%0d", r), rmask, rdw, 1'b0, 40,
                    int'($urandom_range(5, 40)), -1, 1'b1, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
